// File: rtl/fp_mult_sched_pkg.sv
// Shared types for the fp_mult_top request scheduler: FSM states, the
// {valid, id} response tag, rounding-mode encoding and multiplier status flags.
package fp_mult_sched_pkg;

  // Widest requester id needed for the largest legal NREQ (8).
  localparam int unsigned ID_W     = 3;
  localparam int unsigned MAX_NREQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // Same encoding as the fp_mult_top round input.
  typedef enum logic [2:0] {
    IEEE_near    = 3'd0,
    IEEE_zero    = 3'd1,
    IEEE_pos_inf = 3'd2,
    IEEE_neg_inf = 3'd3,
    near_maj     = 3'd4
  } round_e;

  // fp_mult_top status flag bits; the scheduler passes them through untouched.
  localparam logic [7:0] ST_INVALID   = 8'h01;
  localparam logic [7:0] ST_DIVZERO   = 8'h02;
  localparam logic [7:0] ST_OVERFLOW  = 8'h04;
  localparam logic [7:0] ST_UNDERFLOW = 8'h08;
  localparam logic [7:0] ST_INEXACT   = 8'h10;

endpackage

// File: rtl/fp_mult_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after 'pointer', wrapping
// NREQ-1 -> 0. Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  // Scan NREQ positions starting one past the pointer; first hit wins.
  always_comb begin
    int          tmp;
    logic [IW-1:0] idx;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    tmp       = 0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      tmp = int'(pointer) + k;
      if (tmp >= NREQ) tmp = tmp - NREQ;
      idx = IW'(tmp);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fp_mult_sched.sv
// Scheduler sharing one fixed-latency fp_mult_top among NREQ requesters.
// Round-robin issue (one per cycle), a LAT-deep {valid,id} tag pipeline
// routes each result back to its owner, IDLE/RUN/DRAIN FSM gates issue.
// Optional build macro FP_MULT_SCHED_PERF_CNT_EN adds per-requester issue
// counters on output issue_cnt.
//
//   state | meaning
//   IDLE  | no grants, pipeline empty
//   RUN   | grants issued while en=1
//   DRAIN | en dropped, waiting for in-flight results to return
module fp_mult_sched
  import fp_mult_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0][31:0] req_a,
  input  logic [NREQ-1:0][31:0] req_b,
  input  logic [NREQ-1:0][2:0]  req_round,
  output logic [NREQ-1:0]       req_ready,
  output logic [31:0]           m_a,
  output logic [31:0]           m_b,
  output logic [2:0]            m_round,
  input  logic [31:0]           m_z,
  input  logic [7:0]            m_status,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [31:0]           rsp_z,
  output logic [7:0]            rsp_status,
  output logic                  busy
`ifdef FP_MULT_SCHED_PERF_CNT_EN
  ,
  output logic [NREQ-1:0][31:0] issue_cnt
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_e  state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  tag_t          tag_q [LAT];
  tag_t          tag_d [LAT];

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            grant_en;
  logic            xfer;
  logic            tags_busy;
  logic            rsp_hit;
  tag_t            out_tag;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req       (req_valid),
    .pointer   (ptr_q),
    .grant     (arb_gnt),
    .grant_idx (arb_idx)
  );

  // Grant gating, operand mux to the shared multiplier, zero when idle.
  // rst also blocks issue so nothing is captured in the reset cycle.
  always_comb begin
    grant_en  = (state_q == RUN) && en && !rst;
    req_ready = grant_en ? arb_gnt : '0;
    xfer      = |req_ready;
    m_a       = xfer ? req_a[arb_idx]     : 32'h0;
    m_b       = xfer ? req_b[arb_idx]     : 32'h0;
    m_round   = xfer ? req_round[arb_idx] : 3'h0;
  end

  // Response routing from the tail of the tag pipeline; masked during rst so
  // tags issued before reset never reach a requester.
  always_comb begin
    tags_busy = 1'b0;
    for (int i = 0; i < LAT; i++) tags_busy = tags_busy | tag_q[i].valid;
    out_tag    = tag_q[LAT-1];
    rsp_hit    = out_tag.valid && !rst;
    rsp_valid  = '0;
    for (int i = 0; i < NREQ; i++) rsp_valid[i] = rsp_hit && (out_tag.id == ID_W'(i));
    rsp_z      = rsp_hit ? m_z      : 32'h0;
    rsp_status = rsp_hit ? m_status : 8'h0;
    busy       = (state_q != IDLE) || tags_busy;
  end

  // Next state, pointer and tag shift.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = tags_busy ? DRAIN : IDLE;
      DRAIN: begin
        if (en)              state_d = RUN;
        else if (!tags_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ptr_d = xfer ? arb_idx : ptr_q;

    tag_d[0].valid = xfer;
    tag_d[0].id    = xfer ? ID_W'(arb_idx) : '0;
    for (int i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];
  end

  // State, pointer and tag registers; pointer resets to NREQ-1 so requester 0
  // has first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

`ifdef FP_MULT_SCHED_PERF_CNT_EN
  logic [NREQ-1:0][31:0] cnt_q, cnt_d;

  // Per-requester transfer counters, wrapping naturally at 2^32.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && req_valid[i]) cnt_d[i] = cnt_q[i] + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign issue_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fp_mult_sched.sv
// Testbench for fp_mult_sched: a stand-in fixed-latency multiplier, a
// scoreboard of expected responses, directed scenarios and a random phase.
module tb_fp_mult_sched;
  import fp_mult_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [NREQ-1:0][2:0]  req_round;
  logic [NREQ-1:0]       req_ready;
  logic [31:0]           m_a, m_b;
  logic [2:0]            m_round;
  logic [31:0]           m_z;
  logic [7:0]            m_status;
  logic [NREQ-1:0]       rsp_valid;
  logic [31:0]           rsp_z;
  logic [7:0]            rsp_status;
  logic                  busy;
`ifdef FP_MULT_SCHED_PERF_CNT_EN
  logic [NREQ-1:0][31:0] issue_cnt;
`endif

  fp_mult_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_round  (req_round),
    .req_ready  (req_ready),
    .m_a        (m_a),
    .m_b        (m_b),
    .m_round    (m_round),
    .m_z        (m_z),
    .m_status   (m_status),
    .rsp_valid  (rsp_valid),
    .rsp_z      (rsp_z),
    .rsp_status (rsp_status),
    .busy       (busy)
`ifdef FP_MULT_SCHED_PERF_CNT_EN
    ,
    .issue_cnt  (issue_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple truncating single-precision multiply (denormals flushed to zero).
  function automatic logic [39:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic sgn, a_inf, b_inf, a_nan, b_nan, a_zero, b_zero, inex;
    logic [47:0] p;
    logic [22:0] man;
    int e;
    sgn    = a[31] ^ b[31];
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {ST_INVALID, 32'h7FC00000};
    if (a_inf || b_inf) return {8'h00, sgn, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {8'h00, sgn, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e++;
      man  = p[46:24];
      inex = |p[23:0];
    end else begin
      man  = p[45:23];
      inex = |p[22:0];
    end
    if (e >= 255) return {ST_OVERFLOW | ST_INEXACT, sgn, 8'hFF, 23'h0};
    if (e <= 0) return {ST_UNDERFLOW | ST_INEXACT, sgn, 31'h0};
    return {(inex ? ST_INEXACT : 8'h00), sgn, 8'(e), man};
  endfunction

  // Stand-in fp_mult_top: operands captured at the edge, result LAT cycles on.
  logic [31:0] pa [LAT];
  logic [31:0] pb [LAT];
  always @(posedge clk) begin
    pa[0] <= m_a;
    pb[0] <= m_b;
    for (int i = 1; i < LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end
  assign {m_status, m_z} = fmul(pa[LAT-1], pb[LAT-1]);

  typedef struct {
    int          id;
    logic [31:0] z;
    logic [7:0]  st;
    int          cyc;
  } exp_t;

  exp_t         sbq[$];
  int           gnt_log[$];
  int           rsp_log[$];
  int           rsp_cyc[$];
  int           n_chk  = 0;
  int           n_fail = 0;
  int           cyc    = 0;
  int           rr_last = NREQ - 1;
  sched_state_e mstate = IDLE;
  logic [31:0]  last_z;
  logic [7:0]   last_st;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor: checks responses against the scoreboard, grants against the
  // round-robin model, and advances the model state once per cycle.
  always @(negedge clk) begin
    int              inflight;
    int              pick;
    int              idx;
    logic [NREQ-1:0] exp_rdy;
    logic [39:0]     r;
    exp_t            e;
    cyc++;
    if (rst) begin
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      sbq.delete();
      mstate  = IDLE;
      rr_last = NREQ - 1;
    end else begin
      inflight = sbq.size();
      chk("busy", 64'(busy), 64'((mstate != IDLE) || (inflight > 0)));

      if (rsp_valid != 0) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          e = sbq.pop_front();
          chk("rsp_owner", 64'(rsp_valid), 64'(1) << e.id);
          chk("rsp_z", 64'(rsp_z), 64'(e.z));
          chk("rsp_status", 64'(rsp_status), 64'(e.st));
          chk("rsp_latency", 64'(cyc - e.cyc), 64'(LAT));
        end
        rsp_log.push_back(onehot_idx(rsp_valid));
        rsp_cyc.push_back(cyc);
        last_z  = rsp_z;
        last_st = rsp_status;
      end else begin
        chk("rsp_idle_zero", {24'h0, rsp_status, rsp_z}, 64'(0));
        if (sbq.size() > 0 && sbq[0].cyc + LAT <= cyc) begin
          chk("rsp_missing", 64'(rsp_valid), 64'(1) << sbq[0].id);
          void'(sbq.pop_front());
        end
      end

      exp_rdy = '0;
      pick    = -1;
      if (mstate == RUN && en) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (rr_last + k) % NREQ;
          if (pick < 0 && req_valid[idx]) pick = idx;
        end
      end
      if (pick >= 0) exp_rdy[pick] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (req_ready != 0) gnt_log.push_back(onehot_idx(req_ready));

      if (pick >= 0) begin
        chk("m_a", 64'(m_a), 64'(req_a[pick]));
        chk("m_b", 64'(m_b), 64'(req_b[pick]));
        chk("m_round", 64'(m_round), 64'(req_round[pick]));
        r = fmul(req_a[pick], req_b[pick]);
        e.id  = pick;
        e.z   = r[31:0];
        e.st  = r[39:32];
        e.cyc = cyc;
        sbq.push_back(e);
        rr_last = pick;
      end else begin
        chk("m_idle_zero", {29'h0, m_round, m_a}, 64'(0));
        chk("m_b_idle_zero", 64'(m_b), 64'(0));
      end

      case (mstate)
        IDLE:  if (en) mstate = RUN;
        RUN:   if (!en) mstate = (inflight > 0) ? DRAIN : IDLE;
        DRAIN: if (en) mstate = RUN; else if (inflight == 0) mstate = IDLE;
        default: mstate = IDLE;
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    rsp_log.delete();
    rsp_cyc.delete();
  endtask

  task automatic drain();
    req_valid = '0;
    for (int k = 0; k < 60; k++) begin
      if (sbq.size() == 0) break;
      step(1);
    end
    chk("drain_timeout", 64'(sbq.size()), 64'(0));
  endtask

  task automatic wait_grants(input int n);
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (gnt_log.size() >= n) break;
    end
    req_valid = '0;
    chk("grant_wait", 64'(gnt_log.size()), 64'(n));
  endtask

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i]     = rand_fp();
      req_b[i]     = rand_fp();
      req_round[i] = 3'($urandom_range(0, 4));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = '0;
    req_a = '0; req_b = '0; req_round = '0;
    step(3);
    rst = 1'b0;
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_m_a", 64'(m_a), 64'(0));
    chk("reset_rsp_z", 64'(rsp_z), 64'(0));

    // 2.0 * 3.0 from requester 0
    clear_logs();
    en = 1'b1;
    req_a[0] = 32'h40000000; req_b[0] = 32'h40400000; req_round[0] = IEEE_near;
    req_valid = 4'b0001;
    wait_grants(1);
    drain();
    chk("mul_2x3_z", 64'(last_z), 64'h40C00000);
    chk("mul_2x3_rsp_cnt", 64'(rsp_log.size()), 64'(1));

    // all four valid for 8 cycles
    do_reset();
    en = 1'b1;
    step(2);
    clear_logs();
    rand_ops();
    req_valid = 4'hF;
    step(8);
    drain();
    chk("rr_gnt_cnt", 64'(gnt_log.size()), 64'(8));
    chk("rr_rsp_cnt", 64'(rsp_log.size()), 64'(8));
    for (int k = 0; k < 8; k++) begin
      if (k < gnt_log.size()) chk("rr_gnt_order", 64'(gnt_log[k]), 64'(k % 4));
      if (k < rsp_log.size()) chk("rr_rsp_order", 64'(rsp_log[k]), 64'(k % 4));
    end

    // requester 2 alone for 5 cycles
    clear_logs();
    rand_ops();
    req_valid = 4'b0100;
    step(5);
    drain();
    chk("solo_gnt_cnt", 64'(gnt_log.size()), 64'(5));
    chk("solo_rsp_cnt", 64'(rsp_log.size()), 64'(5));
    for (int k = 0; k < 5; k++) begin
      if (k < gnt_log.size()) chk("solo_gnt_id", 64'(gnt_log[k]), 64'(2));
      if (k < rsp_log.size()) chk("solo_rsp_id", 64'(rsp_log[k]), 64'(2));
      if (k > 0 && k < rsp_cyc.size()) chk("solo_b2b", 64'(rsp_cyc[k] - rsp_cyc[k-1]), 64'(1));
    end

    // en dropped with LAT operations in flight
    clear_logs();
    rand_ops();
    req_valid = 4'hF;
    step(LAT);
    en = 1'b0;
    step(LAT + 4);
    chk("drain_no_new_gnt", 64'(gnt_log.size()), 64'(LAT));
    chk("drain_rsp_cnt", 64'(rsp_log.size()), 64'(LAT));
    chk("drain_busy_low", 64'(busy), 64'(0));
    req_valid = '0;

    // reset one cycle after an issue
    en = 1'b1;
    step(2);
    clear_logs();
    req_valid = 4'b1000;
    step(1);
    req_valid = '0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    req_valid = 4'hF;
    wait_grants(2);
    drain();
    if (gnt_log.size() >= 2) chk("post_rst_gnt", 64'(gnt_log[1]), 64'(0));
    chk("post_rst_rsp_cnt", 64'(rsp_log.size()), 64'(1));
    if (rsp_log.size() >= 1) chk("post_rst_rsp_id", 64'(rsp_log[0]), 64'(0));

    // +inf * +0
    clear_logs();
    req_a[1] = 32'h7F800000; req_b[1] = 32'h00000000; req_round[1] = IEEE_near;
    req_valid = 4'b0010;
    wait_grants(1);
    drain();
    chk("inf_x_zero_z", 64'(last_z), 64'h7FC00000);
    chk("inf_x_zero_status", 64'(last_st), 64'(ST_INVALID));

    // random traffic with occasional en drops and resets
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      en        = ($urandom_range(0, 9) != 0);
      req_valid = 4'($urandom);
      rand_ops();
      if ($urandom_range(0, 19) == 0) begin
        req_a[0] = 32'h7F800000;
        req_b[0] = 32'h80000000;
      end
      step(1);
    end
    rst = 1'b0;
    en  = 1'b1;
    drain();
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
